// File: rtl/clint_smp.sv
// ============================================================================
// Module   : clint_smp
// Purpose  : Core-local interruptor (mtime, per-hart mtimecmp/msip) for SMP.
//            Optional tear-free mtime read: define CLINT_MTIME_SNAPSHOT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clint_smp #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_req,
  input  logic               w_we,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  input  logic               w_tick_en,
  output logic               r_ack,
  output logic [31:0]        r_rdata,
  output logic               r_err,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);

  localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PMAX = c_PW'(TICK_DIV - 1);
  localparam logic [13:0] c_MTIME_LO_W = 14'h2FFE;
  localparam logic [13:0] c_MTIME_HI_W = 14'h2FFF;

  logic [c_PW-1:0]          r_presc;
  logic [63:0]              r_mtime;
  logic [63:0]              r_mtimecmp [N_HARTS];
  logic [N_HARTS-1:0]       r_msip;
  logic [N_HARTS-1:0]       r_mtip;

  logic                     w_tick;
  logic                     w_is_msip;
  logic                     w_is_cmp;
  logic                     w_is_mtlo;
  logic                     w_is_mthi;
  logic [N_HARTS-1:0]       w_msip_sel;
  logic [N_HARTS-1:0]       w_cmp_sel;
  logic                     w_mapped;
  logic                     w_wr;
  logic                     w_rd;
  logic [31:0]              w_rd_data;
  logic                     w_unused_addr;

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0]              r_snap;
  logic                     r_snap_vld;
`endif

  assign w_unused_addr = &{1'b0, w_addr[1:0]};

  assign w_tick    = w_tick_en && (r_presc == c_PMAX);
  assign w_is_msip = (w_addr[15:14] == 2'b00);
  assign w_is_cmp  = (w_addr[15:14] == 2'b01);
  assign w_is_mtlo = (w_addr[15:2] == c_MTIME_LO_W);
  assign w_is_mthi = (w_addr[15:2] == c_MTIME_HI_W);

  // Hart decode by equality so out-of-range indices simply select nothing.
  generate
    for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
      assign w_msip_sel[h] = w_is_msip && (w_addr[13:2] == 12'(h));
      assign w_cmp_sel[h]  = w_is_cmp  && (w_addr[13:3] == 11'(h));
    end
  endgenerate

  assign w_mapped = (|w_msip_sel) || (|w_cmp_sel) || w_is_mtlo || w_is_mthi;
  assign w_wr     = w_req && w_we;
  assign w_rd     = w_req && !w_we;

  always_comb begin
    w_rd_data = 32'h0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (w_msip_sel[h]) w_rd_data = {31'h0, r_msip[h]};
      if (w_cmp_sel[h])  w_rd_data = w_addr[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
    end
    if (w_is_mtlo) w_rd_data = r_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
    if (w_is_mthi) w_rd_data = r_snap_vld ? r_snap : r_mtime[63:32];
`else
    if (w_is_mthi) w_rd_data = r_mtime[63:32];
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      r_presc <= '0;
      r_mtime <= 64'h0;
    end else begin
      if (w_tick_en) r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      // A write to either half wins over a same-cycle tick.
      if (w_wr && w_is_mtlo)      r_mtime <= {r_mtime[63:32], w_wdata};
      else if (w_wr && w_is_mthi) r_mtime <= {w_wdata, r_mtime[31:0]};
      else if (w_tick)            r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      r_msip <= '0;
      r_mtip <= '0;
      for (int h = 0; h < N_HARTS; h++) r_mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
        if (w_wr && w_msip_sel[h]) r_msip[h] <= w_wdata[0];
        if (w_wr && w_cmp_sel[h]) begin
          if (w_addr[2]) r_mtimecmp[h][63:32] <= w_wdata;
          else           r_mtimecmp[h][31:0]  <= w_wdata;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rd_data : 32'h0;
      r_err   <= w_req && !w_mapped;
    end
  end

`ifdef CLINT_MTIME_SNAPSHOT_EN
  always_ff @(posedge CLK) begin
    if (RST_X) begin
      r_snap     <= 32'h0;
      r_snap_vld <= 1'b0;
    end else if (w_rd && w_is_mtlo) begin
      r_snap     <= r_mtime[63:32];
      r_snap_vld <= 1'b1;
    end else if ((w_rd && w_is_mthi) || (w_wr && (w_is_mtlo || w_is_mthi))) begin
      r_snap_vld <= 1'b0;
    end
  end
`endif

  assign w_mtime = r_mtime;
  assign w_mtip  = r_mtip;
  assign w_msip  = r_msip;

endmodule

`default_nettype wire

// File: tb/tb_clint_smp.sv
// ============================================================================
// Module   : tb_clint_smp
// Purpose  : Directed self-checking bench for clint_smp (2 harts, TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clint_smp;

  localparam int c_NH = 2;
  localparam int c_TD = 4;

  logic            CLK;
  logic            RST_X;
  logic            w_req;
  logic            w_we;
  logic [15:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_tick_en;
  logic            r_ack;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [63:0]     w_mtime;
  logic [c_NH-1:0] w_mtip;
  logic [c_NH-1:0] w_msip;

  int total = 0;
  int bad   = 0;

  clint_smp #(.N_HARTS(c_NH), .TICK_DIV(c_TD)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_addr(w_addr),
    .w_wdata(w_wdata), .w_tick_en(w_tick_en), .r_ack(r_ack), .r_rdata(r_rdata),
    .r_err(r_err), .w_mtime(w_mtime), .w_mtip(w_mtip), .w_msip(w_msip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request cycle; on return the response of that request is on the outputs.
  task automatic mmio(input logic we, input logic [15:0] a, input logic [31:0] d);
    w_req = 1'b1; w_we = we; w_addr = a; w_wdata = d;
    @(negedge CLK);
    w_req = 1'b0; w_we = 1'b0; w_addr = 16'h0; w_wdata = 32'h0;
  endtask

  // Run ticks until mtime equals target, then freeze (prescaler left at 0).
  task automatic run_to(input string tag, input logic [63:0] target);
    int n = 0;
    w_tick_en = 1'b1;
    while (w_mtime !== target && n < 200) begin
      @(negedge CLK);
      n++;
    end
    w_tick_en = 1'b0;
    chk(tag, w_mtime, target);
  endtask

  initial begin
    logic [31:0] exp_hi;
    int n;
    RST_X = 1'b1; w_req = 1'b0; w_we = 1'b0; w_addr = 16'h0; w_wdata = 32'h0; w_tick_en = 1'b0;
    repeat (3) @(negedge CLK);
    RST_X = 1'b0;

    // Reset state
    chk("rst_mtime", w_mtime, 64'h0);
    chk("rst_mtip", 64'(w_mtip), 64'h0);
    chk("rst_msip", 64'(w_msip), 64'h0);
    chk("rst_ack", 64'(r_ack), 64'h0);

    // mtimecmp reset value readback
    mmio(1'b0, 16'h4000, 32'h0);
    chk("cmp0lo_ack", 64'(r_ack), 64'h1);
    chk("cmp0lo_data", 64'(r_rdata), 64'hFFFF_FFFF);
    chk("cmp0lo_err", 64'(r_err), 64'h0);
    mmio(1'b0, 16'h4004, 32'h0);
    chk("cmp0hi_data", 64'(r_rdata), 64'hFFFF_FFFF);
    mmio(1'b0, 16'h400C, 32'h0);
    chk("cmp1hi_data", 64'(r_rdata), 64'hFFFF_FFFF);
    chk("cmp1hi_err", 64'(r_err), 64'h0);
    chk("post_rst_mtip", 64'(w_mtip), 64'h0);
    @(negedge CLK);
    chk("ack_drop", 64'(r_ack), 64'h0);

    // Prescaler: 40 enabled cycles at /4 gives 10, then freeze
    w_tick_en = 1'b1;
    repeat (40) @(negedge CLK);
    w_tick_en = 1'b0;
    chk("presc_40", w_mtime, 64'd10);
    repeat (8) @(negedge CLK);
    chk("presc_hold", w_mtime, 64'd10);

    // msip per hart and out-of-range hart
    mmio(1'b1, 16'h0004, 32'h1);
    chk("msip1_set", 64'(w_msip), 64'h2);
    chk("msip1_err", 64'(r_err), 64'h0);
    chk("msip1_wr_rdata", 64'(r_rdata), 64'h0);
    mmio(1'b1, 16'h0008, 32'h1);
    chk("msip2_err", 64'(r_err), 64'h1);
    chk("msip2_nochg", 64'(w_msip), 64'h2);
    mmio(1'b0, 16'h0004, 32'h0);
    chk("msip1_rd", 64'(r_rdata), 64'h1);
    mmio(1'b1, 16'h0004, 32'h0);
    chk("msip1_clr", 64'(w_msip), 64'h0);
    mmio(1'b0, 16'h8000, 32'h0);
    chk("unmap_err", 64'(r_err), 64'h1);
    chk("unmap_data", 64'(r_rdata), 64'h0);
    mmio(1'b0, 16'h4010, 32'h0);
    chk("cmp2_err", 64'(r_err), 64'h1);

    // Timer interrupt on hart 0
    mmio(1'b1, 16'h4004, 32'h0);
    mmio(1'b1, 16'h4000, 32'd20);
    @(negedge CLK);
    chk("mtip_below", 64'(w_mtip), 64'h0);
    w_tick_en = 1'b1;
    n = 0;
    while (w_mtime !== 64'd20 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("mtime_reach20", w_mtime, 64'd20);
    chk("mtip_not_yet", 64'(w_mtip), 64'h0);
    @(negedge CLK);
    w_tick_en = 1'b0;
    chk("mtip_rise", 64'(w_mtip), 64'h1);
    mmio(1'b1, 16'h4000, 32'hFFFF_FFFF);
    chk("mtip_still", 64'(w_mtip), 64'h1);
    @(negedge CLK);
    chk("mtip_clear", 64'(w_mtip), 64'h0);

    // mtime half writes, snapshot, carry into hi
    mmio(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    mmio(1'b1, 16'hBFFC, 32'h0);
    chk("mtime_wr", w_mtime, 64'h0000_0000_FFFF_FFFF);
    mmio(1'b0, 16'hBFF8, 32'h0);
    chk("mtlo_rd", 64'(r_rdata), 64'hFFFF_FFFF);
    run_to("carry1", 64'h1_0000_0000);
    mmio(1'b0, 16'hBFFC, 32'h0);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    chk("mthi_rd", 64'(r_rdata), 64'(exp_hi));
    mmio(1'b0, 16'hBFFC, 32'h0);
    chk("mthi_live", 64'(r_rdata), 64'h1);
    run_to("carry2", 64'h1_0000_0001);

    // Write lands on the same edge as a tick (prescaler at 0 now)
    w_tick_en = 1'b1;
    repeat (3) @(negedge CLK);
    mmio(1'b1, 16'hBFF8, 32'h0000_1234);
    w_tick_en = 1'b0;
    chk("wr_tick", w_mtime, 64'h1_0000_1234);
    repeat (2) @(negedge CLK);
    chk("wr_tick_hold", w_mtime, 64'h1_0000_1234);

    // Back-to-back requests
    w_req = 1'b1; w_we = 1'b0; w_addr = 16'h400C;
    @(negedge CLK);
    chk("b2b_ack0", 64'(r_ack), 64'h1);
    chk("b2b_data0", 64'(r_rdata), 64'hFFFF_FFFF);
    w_addr = 16'hBFF8;
    @(negedge CLK);
    w_req = 1'b0; w_addr = 16'h0;
    chk("b2b_ack1", 64'(r_ack), 64'h1);
    chk("b2b_data1", 64'(r_rdata), 64'h0000_1234);

    // Reset during a request
    mmio(1'b1, 16'h0000, 32'h1);
    chk("msip0_set", 64'(w_msip), 64'h1);
    w_req = 1'b1; w_we = 1'b0; w_addr = 16'hBFF8; RST_X = 1'b1;
    @(negedge CLK);
    w_req = 1'b0; w_addr = 16'h0; RST_X = 1'b0;
    chk("rstreq_ack", 64'(r_ack), 64'h0);
    chk("rstreq_mtime", w_mtime, 64'h0);
    chk("rstreq_msip", 64'(w_msip), 64'h0);
    mmio(1'b0, 16'h4000, 32'h0);
    chk("rstreq_cmp", 64'(r_rdata), 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
